multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Moore-style control FSM for the multi-cycle MIPS datapath; sits directly upstream of the ALU.
- Each cycle it drives the ALU's 4-bit operation code plus datapath mux selects and register/memory write enables.
- Sequences fetch, decode, execute, memory and writeback from the IR opcode/funct fields and the ALU Zero flag.
- Waits on a memory-ready handshake with a bounded timeout.

Parameters:
- WAIT_LIMIT, 15: max cycles to wait for mem_ready in a memory state before aborting with bus_err (range 1..255).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26], stable from the cycle after IF completes
- funct  in  6  IR[5:0]
- Zero  in  1  ALU Zero flag (BEQ: src1==src2; BNE: src1!=src2)
- mem_ready  in  1  memory completes the current access this cycle
- ALUOp  out  4  0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOR, 7 SLT, 8 SLL, 9 SRL, A BEQ, B BNE
- ALUSrcA  out  1  0 = PC, 1 = regA
- ALUSrcB  out  2  00 regB, 01 const 4, 10 ext imm, 11 ext imm<<2
- ExtOp  out  1  1 = sign-extend, 0 = zero-extend
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemRead  out  1
- MemWrite  out  1
- IRWrite  out  1
- PCWrite  out  1
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- RegWrite  out  1
- RegDst  out  1  1 = rd, 0 = rt
- MemtoReg  out  1
- illegal  out  1  one-cycle pulse: undecodable instruction
- bus_err  out  1  one-cycle pulse: mem_ready timeout
- instr_done  out  1  one-cycle pulse on an instruction's final cycle

Behaviour:
- rst low → state = IF, wait counter = 0.
  - While rst is low, every enable (PCWrite, IRWrite, MemRead, MemWrite, RegWrite) and all pulses are forced to 0.
  - All other outputs hold their IF values.
- Outputs are a function of state only; exceptions: ALUOp from opcode/funct, PCWrite from Zero/mem_ready. Unlisted outputs = 0.
- IF (0):
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00.
  - IRWrite = PCWrite = mem_ready.
  - mem_ready=1 → ID, else stay.
- ID (1):
  - Outputs: ALUSrcA=0, ALUSrcB=11, ExtOp=1, ALUOp=ADD (branch target into ALUOut).
  - Next state by opcode:
    - 00 → EXR if funct ∈ {20 add, 22 sub, 24 and, 25 or, 26 xor, 27 nor, 2A slt, 00 sll, 02 srl}.
    - 23/2B → MEMADR.
    - 08/0C/0D/0A → EXI.
    - 04/05 → BR.
    - 02 → JMP.
    - Anything else → IF with illegal=1 and instr_done=1.
- MEMADR (2): ALUSrcA=1, ALUSrcB=10, ExtOp=1, ADD; lw → MEMRD, sw → MEMWR.
- MEMRD (3): IorD=1, MemRead=1; mem_ready → WBMEM.
- WBMEM (4): RegWrite=1, RegDst=0, MemtoReg=1, instr_done=1 → IF.
- MEMWR (5): IorD=1, MemWrite=1; mem_ready → IF with instr_done=1.
- EXR (6):
  - ALUSrcA=1, ALUSrcB=00 → WBR.
  - ALUOp by funct: 20 ADD, 22 SUB, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT, 00 SLL, 02 SRL.
- WBR (7): RegWrite=1, RegDst=1, instr_done=1 → IF.
- EXI (8):
  - ALUSrcA=1, ALUSrcB=10 → WBI.
  - addi: ADD, ExtOp=1. slti: SLT, ExtOp=1. andi: AND, ExtOp=0. ori: OR, ExtOp=0.
- WBI (9): RegWrite=1, RegDst=0, instr_done=1 → IF.
- BR (10):
  - ALUSrcA=1, ALUSrcB=00, ALUOp = BEQ (04) / BNE (05), PCSource=01.
  - PCWrite = Zero; instr_done=1 → IF.
- JMP (11): PCSource=10, PCWrite=1, instr_done=1 → IF.
- Unused state codes 12–15 → IF next cycle; all outputs 0.
- Wait counter (8-bit):
  - Cleared on every state change; increments each cycle in IF/MEMRD/MEMWR while mem_ready=0.
  - Reaching WAIT_LIMIT with mem_ready=0 → bus_err=1 for that cycle, next state IF, no PC/IR/Reg write.
  - A MEMRD/MEMWR timeout also asserts instr_done.
  - mem_ready=1 on the limit cycle wins: normal completion, no bus_err.
- Latency: R/I-type 4 cycles, lw 5, sw 4, beq/bne 3, j 3, each with zero memory wait states.
- rst asserted mid-instruction → immediate return to IF; no partial write-back is issued afterwards.

Test Plan:
- Reset: rst=0 mid-EXR, released → state IF; PCWrite=RegWrite=MemWrite=0 during reset; first cycle after release MemRead=1, ALUOp=1.
- add (op 00, funct 20), mem_ready=1 → IF, ID, EXR (ALUOp=1), WBR (RegWrite=1, RegDst=1, instr_done=1); 4 cycles. Repeat for funct 27 → ALUOp=6 and funct 02 → ALUOp=9.
- lw (op 23), mem_ready low 3 cycles in MEMRD → MEMRD held 4 cycles, then WBMEM with MemtoReg=1; total 8 cycles.
- beq with Zero=1 → PCWrite=1, PCSource=01. bne (op 05) with Zero=0 → PCWrite=0, ALUOp=B.
- Illegal op 3F → illegal=1 in ID, next state IF. ori (0D) → ExtOp=0, ALUOp=4 in EXI.
- mem_ready held 0 in MEMWR with WAIT_LIMIT=15 → bus_err pulse after 15 cycles, MemWrite drops, next state IF.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for the multi-cycle MIPS datapath with a bounded mem_ready wait
// Ports:
//   clk, rst (async, active-low)
//   opcode, funct      IR fields used for decode and ALU op selection
//   Zero, mem_ready    ALU branch condition and memory completion handshake
//   ALUOp, ALUSrcA, ALUSrcB, ExtOp, IorD, PCSource, RegDst, MemtoReg   datapath selects
//   MemRead, MemWrite, IRWrite, PCWrite, RegWrite                      enables (0 while in reset)
//   illegal, bus_err, instr_done                                        one-cycle status pulses
module multicycle_ctrl #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic [3:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ExtOp,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [1:0] PCSource,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       illegal,
    output logic       bus_err,
    output logic       instr_done
);
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_NOR = 4'h6;
    localparam logic [3:0] OP_SLT = 4'h7;
    localparam logic [3:0] OP_SLL = 4'h8;
    localparam logic [3:0] OP_SRL = 4'h9;
    localparam logic [3:0] OP_BEQ = 4'hA;
    localparam logic [3:0] OP_BNE = 4'hB;

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_WBMEM  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXR    = 4'd6,
        S_WBR    = 4'd7,
        S_EXI    = 4'd8,
        S_WBI    = 4'd9,
        S_BR     = 4'd10,
        S_JMP    = 4'd11
    } state_t;

    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic [3:0] r_op, i_op;
    logic       r_ok, waiting, timeout;
    logic       pc_w, ir_w, mem_rd, mem_wr, reg_w, ill, berr, done;

    // R-type funct and I-type opcode to ALU operation; NOP marks undecodable
    always_comb begin
        case (funct)
            6'h20:   r_op = OP_ADD;
            6'h22:   r_op = OP_SUB;
            6'h24:   r_op = OP_AND;
            6'h25:   r_op = OP_OR;
            6'h26:   r_op = OP_XOR;
            6'h27:   r_op = OP_NOR;
            6'h2A:   r_op = OP_SLT;
            6'h00:   r_op = OP_SLL;
            6'h02:   r_op = OP_SRL;
            default: r_op = OP_NOP;
        endcase
        case (opcode)
            6'h08:   i_op = OP_ADD;
            6'h0A:   i_op = OP_SLT;
            6'h0C:   i_op = OP_AND;
            6'h0D:   i_op = OP_OR;
            default: i_op = OP_NOP;
        endcase
    end

    assign r_ok    = r_op != OP_NOP;
    assign waiting = state == S_IF || state == S_MEMRD || state == S_MEMWR;
    // the limit cycle is the one where cnt has already counted WAIT_LIMIT idle cycles
    assign timeout = waiting && !mem_ready && cnt == 8'(WAIT_LIMIT);

    always_comb begin
        state_nx = state;
        ALUOp    = OP_NOP;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ExtOp    = 1'b0;
        IorD     = 1'b0;
        PCSource = 2'b00;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        pc_w     = 1'b0;
        ir_w     = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        reg_w    = 1'b0;
        ill      = 1'b0;
        berr     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IF: begin
                mem_rd   = 1'b1;
                ALUSrcB  = 2'b01;
                ALUOp    = OP_ADD;
                ir_w     = mem_ready;
                pc_w     = mem_ready;
                berr     = timeout;
                state_nx = mem_ready ? S_ID : S_IF;
            end
            S_ID: begin
                ALUSrcB = 2'b11;
                ExtOp   = 1'b1;
                ALUOp   = OP_ADD;
                case (opcode)
                    6'h00:                      state_nx = r_ok ? S_EXR : S_IF;
                    6'h23, 6'h2B:               state_nx = S_MEMADR;
                    6'h08, 6'h0C, 6'h0D, 6'h0A: state_nx = S_EXI;
                    6'h04, 6'h05:               state_nx = S_BR;
                    6'h02:                      state_nx = S_JMP;
                    default:                    state_nx = S_IF;
                endcase
                ill  = state_nx == S_IF;
                done = ill;
            end
            S_MEMADR: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'b10;
                ExtOp    = 1'b1;
                ALUOp    = OP_ADD;
                state_nx = opcode == 6'h23 ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD     = 1'b1;
                mem_rd   = 1'b1;
                berr     = timeout;
                done     = timeout;
                state_nx = mem_ready ? S_WBMEM : timeout ? S_IF : S_MEMRD;
            end
            S_WBMEM: begin
                reg_w    = 1'b1;
                MemtoReg = 1'b1;
                done     = 1'b1;
                state_nx = S_IF;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                mem_wr   = 1'b1;
                berr     = timeout;
                done     = mem_ready || timeout;
                state_nx = (mem_ready || timeout) ? S_IF : S_MEMWR;
            end
            S_EXR: begin
                ALUSrcA  = 1'b1;
                ALUOp    = r_op;
                state_nx = S_WBR;
            end
            S_WBR: begin
                reg_w    = 1'b1;
                RegDst   = 1'b1;
                done     = 1'b1;
                state_nx = S_IF;
            end
            S_EXI: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'b10;
                ALUOp    = i_op;
                ExtOp    = opcode == 6'h08 || opcode == 6'h0A;
                state_nx = S_WBI;
            end
            S_WBI: begin
                reg_w    = 1'b1;
                done     = 1'b1;
                state_nx = S_IF;
            end
            S_BR: begin
                ALUSrcA  = 1'b1;
                ALUOp    = opcode[0] ? OP_BNE : OP_BEQ;
                PCSource = 2'b01;
                pc_w     = Zero;
                done     = 1'b1;
                state_nx = S_IF;
            end
            S_JMP: begin
                PCSource = 2'b10;
                pc_w     = 1'b1;
                done     = 1'b1;
                state_nx = S_IF;
            end
            default: state_nx = S_IF;
        endcase
    end

    // an IF timeout stays in IF, so it must restart the count explicitly
    assign cnt_nx = (state_nx != state || timeout) ? 8'd0 : waiting && !mem_ready ? cnt + 8'd1 : cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IF;
            cnt   <= 8'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // enables and pulses are held off for as long as reset is asserted
    assign PCWrite    = rst && pc_w;
    assign IRWrite    = rst && ir_w;
    assign MemRead    = rst && mem_rd;
    assign MemWrite   = rst && mem_wr;
    assign RegWrite   = rst && reg_w;
    assign illegal    = rst && ill;
    assign bus_err    = rst && berr;
    assign instr_done = rst && done;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;
    logic       clk, rst;
    logic [5:0] opcode, funct;
    logic       Zero, mem_ready;
    logic [3:0] ALUOp;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ExtOp, IorD, MemRead, MemWrite, IRWrite, PCWrite;
    logic [1:0] PCSource;
    logic       RegWrite, RegDst, MemtoReg, illegal, bus_err, instr_done;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       src_a;
        logic [1:0] src_b;
        logic       ext;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       pcw;
        logic [1:0] pcsrc;
        logic       regw;
        logic       regdst;
        logic       m2r;
        logic       ill;
        logic       berr;
        logic       done;
    } outs_t;

    outs_t obs, exp_v;
    outs_t q[$];
    string tq[$];
    string tag_v;
    int    checks = 0;
    int    errors = 0;

    multicycle_ctrl #(.WAIT_LIMIT(15)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .Zero(Zero), .mem_ready(mem_ready),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCSource(PCSource), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .illegal(illegal), .bus_err(bus_err), .instr_done(instr_done)
    );

    assign obs = {ALUOp, ALUSrcA, ALUSrcB, ExtOp, IorD, MemRead, MemWrite, IRWrite, PCWrite,
                  PCSource, RegWrite, RegDst, MemtoReg, illegal, bus_err, instr_done};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_v = q.pop_front();
            tag_v = tq.pop_front();
            checks++;
            assert (obs === exp_v) else begin
                errors++;
                $error("FAIL %s: observed %b expected %b", tag_v, obs, exp_v);
            end
        end
    end

    function automatic outs_t o_rst();
        outs_t o = '0;
        o.alu_op = 4'h1;
        o.src_b  = 2'b01;
        return o;
    endfunction
    function automatic outs_t o_if(logic rdy);
        outs_t o = o_rst();
        o.mrd = 1'b1;
        o.irw = rdy;
        o.pcw = rdy;
        return o;
    endfunction
    function automatic outs_t o_id(logic bad);
        outs_t o = '0;
        o.alu_op = 4'h1;
        o.src_b  = 2'b11;
        o.ext    = 1'b1;
        o.ill    = bad;
        o.done   = bad;
        return o;
    endfunction
    function automatic outs_t o_memadr();
        outs_t o = '0;
        o.alu_op = 4'h1;
        o.src_a  = 1'b1;
        o.src_b  = 2'b10;
        o.ext    = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_memrd();
        outs_t o = '0;
        o.iord = 1'b1;
        o.mrd  = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_wbmem();
        outs_t o = '0;
        o.regw = 1'b1;
        o.m2r  = 1'b1;
        o.done = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_memwr(logic rdy, logic be);
        outs_t o = '0;
        o.iord = 1'b1;
        o.mwr  = 1'b1;
        o.berr = be;
        o.done = rdy | be;
        return o;
    endfunction
    function automatic outs_t o_exr(logic [3:0] op);
        outs_t o = '0;
        o.src_a  = 1'b1;
        o.alu_op = op;
        return o;
    endfunction
    function automatic outs_t o_wbr();
        outs_t o = '0;
        o.regw   = 1'b1;
        o.regdst = 1'b1;
        o.done   = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_exi(logic [3:0] op, logic ext);
        outs_t o = '0;
        o.src_a  = 1'b1;
        o.src_b  = 2'b10;
        o.alu_op = op;
        o.ext    = ext;
        return o;
    endfunction
    function automatic outs_t o_wbi();
        outs_t o = '0;
        o.regw = 1'b1;
        o.done = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_br(logic [3:0] op, logic pcw);
        outs_t o = '0;
        o.src_a  = 1'b1;
        o.alu_op = op;
        o.pcsrc  = 2'b01;
        o.pcw    = pcw;
        o.done   = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_jmp();
        outs_t o = '0;
        o.pcsrc = 2'b10;
        o.pcw   = 1'b1;
        o.done  = 1'b1;
        return o;
    endfunction

    // one clock cycle: drive inputs, queue the outputs expected during it
    task automatic step(input string tag, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic rdy, input outs_t e);
        opcode    = op;
        funct     = fn;
        Zero      = z;
        mem_ready = rdy;
        q.push_back(e);
        tq.push_back(tag);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic rtype(input string tag, input logic [5:0] fn, input logic [3:0] op);
        step({tag, "_if"}, 6'h00, fn, 1'b0, 1'b1, o_if(1'b1));
        step({tag, "_id"}, 6'h00, fn, 1'b0, 1'b1, o_id(1'b0));
        step({tag, "_ex"}, 6'h00, fn, 1'b0, 1'b1, o_exr(op));
        step({tag, "_wb"}, 6'h00, fn, 1'b0, 1'b1, o_wbr());
    endtask

    initial begin
        outs_t e;
        rst = 1'b0;
        opcode = 6'h00;
        funct = 6'h00;
        Zero = 1'b0;
        mem_ready = 1'b0;
        step("rst_a", 6'h00, 6'h20, 1'b0, 1'b1, o_rst());
        step("rst_b", 6'h00, 6'h20, 1'b0, 1'b1, o_rst());
        rst = 1'b1;
        rtype("add", 6'h20, 4'h1);
        rtype("nor", 6'h27, 4'h6);
        rtype("srl", 6'h02, 4'h9);
        rtype("slt", 6'h2A, 4'h7);
        step("lw_if", 6'h23, 6'h00, 1'b0, 1'b1, o_if(1'b1));
        step("lw_id", 6'h23, 6'h00, 1'b0, 1'b1, o_id(1'b0));
        step("lw_adr", 6'h23, 6'h00, 1'b0, 1'b0, o_memadr());
        for (int i = 0; i < 3; i++) step("lw_wait", 6'h23, 6'h00, 1'b0, 1'b0, o_memrd());
        step("lw_rd", 6'h23, 6'h00, 1'b0, 1'b1, o_memrd());
        step("lw_wb", 6'h23, 6'h00, 1'b0, 1'b1, o_wbmem());
        step("beq_if", 6'h04, 6'h00, 1'b1, 1'b1, o_if(1'b1));
        step("beq_id", 6'h04, 6'h00, 1'b1, 1'b1, o_id(1'b0));
        step("beq_br", 6'h04, 6'h00, 1'b1, 1'b1, o_br(4'hA, 1'b1));
        step("bne_if", 6'h05, 6'h00, 1'b0, 1'b1, o_if(1'b1));
        step("bne_id", 6'h05, 6'h00, 1'b0, 1'b1, o_id(1'b0));
        step("bne_br", 6'h05, 6'h00, 1'b0, 1'b1, o_br(4'hB, 1'b0));
        step("ill_if", 6'h3F, 6'h00, 1'b0, 1'b1, o_if(1'b1));
        step("ill_id", 6'h3F, 6'h00, 1'b0, 1'b1, o_id(1'b1));
        step("illf_if", 6'h00, 6'h3F, 1'b0, 1'b1, o_if(1'b1));
        step("illf_id", 6'h00, 6'h3F, 1'b0, 1'b1, o_id(1'b1));
        step("ori_if", 6'h0D, 6'h00, 1'b0, 1'b1, o_if(1'b1));
        step("ori_id", 6'h0D, 6'h00, 1'b0, 1'b1, o_id(1'b0));
        step("ori_ex", 6'h0D, 6'h00, 1'b0, 1'b1, o_exi(4'h4, 1'b0));
        step("ori_wb", 6'h0D, 6'h00, 1'b0, 1'b1, o_wbi());
        step("addi_if", 6'h08, 6'h00, 1'b0, 1'b1, o_if(1'b1));
        step("addi_id", 6'h08, 6'h00, 1'b0, 1'b1, o_id(1'b0));
        step("addi_ex", 6'h08, 6'h00, 1'b0, 1'b1, o_exi(4'h1, 1'b1));
        step("addi_wb", 6'h08, 6'h00, 1'b0, 1'b1, o_wbi());
        step("j_if", 6'h02, 6'h00, 1'b0, 1'b1, o_if(1'b1));
        step("j_id", 6'h02, 6'h00, 1'b0, 1'b1, o_id(1'b0));
        step("j_jmp", 6'h02, 6'h00, 1'b0, 1'b1, o_jmp());
        step("sw_if", 6'h2B, 6'h00, 1'b0, 1'b1, o_if(1'b1));
        step("sw_id", 6'h2B, 6'h00, 1'b0, 1'b1, o_id(1'b0));
        step("sw_adr", 6'h2B, 6'h00, 1'b0, 1'b1, o_memadr());
        step("sw_wr", 6'h2B, 6'h00, 1'b0, 1'b1, o_memwr(1'b1, 1'b0));
        step("swto_if", 6'h2B, 6'h00, 1'b0, 1'b1, o_if(1'b1));
        step("swto_id", 6'h2B, 6'h00, 1'b0, 1'b1, o_id(1'b0));
        step("swto_adr", 6'h2B, 6'h00, 1'b0, 1'b0, o_memadr());
        for (int i = 0; i < 15; i++) step("swto_wait", 6'h2B, 6'h00, 1'b0, 1'b0, o_memwr(1'b0, 1'b0));
        step("swto_err", 6'h2B, 6'h00, 1'b0, 1'b0, o_memwr(1'b0, 1'b1));
        step("swto_next", 6'h2B, 6'h00, 1'b0, 1'b1, o_if(1'b1));
        step("swlim_id", 6'h2B, 6'h00, 1'b0, 1'b1, o_id(1'b0));
        step("swlim_adr", 6'h2B, 6'h00, 1'b0, 1'b0, o_memadr());
        for (int i = 0; i < 15; i++) step("swlim_wait", 6'h2B, 6'h00, 1'b0, 1'b0, o_memwr(1'b0, 1'b0));
        step("swlim_rdy", 6'h2B, 6'h00, 1'b0, 1'b1, o_memwr(1'b1, 1'b0));
        for (int i = 0; i < 15; i++) step("ifto_wait", 6'h00, 6'h20, 1'b0, 1'b0, o_if(1'b0));
        e = o_if(1'b0);
        e.berr = 1'b1;
        step("ifto_err", 6'h00, 6'h20, 1'b0, 1'b0, e);
        for (int i = 0; i < 15; i++) step("ifto_rst_cnt", 6'h00, 6'h20, 1'b0, 1'b0, o_if(1'b0));
        step("mid_if", 6'h00, 6'h20, 1'b0, 1'b1, o_if(1'b1));
        step("mid_id", 6'h00, 6'h20, 1'b0, 1'b1, o_id(1'b0));
        rst = 1'b0;
        step("mid_rst_a", 6'h00, 6'h20, 1'b0, 1'b1, o_rst());
        step("mid_rst_b", 6'h00, 6'h20, 1'b0, 1'b1, o_rst());
        rst = 1'b1;
        rtype("post_rst", 6'h22, 4'h2);
        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
